// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART blocks.
// Oversampling figures are common to the transmitter and receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int HALF_COUNT = OVERSAMPLE / 2;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of the serialiser.
// Flags come from the registered count; pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte FIFO plus 8N1/8E1/8O1/8N2 serialiser.
// Bit timing is taken from the shared 16x clk_enb tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_enb,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  uart_tx_state_t    state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        idx_q, idx_d;
  logic              stop_q, stop_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ovf_q;
  logic              pop;
  logic [7:0]        head;
  logic              last_tick;
  logic              stop_last;

  assign last_tick = clk_enb &&
                     (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign stop_last = (STOP_BITS == 1) || stop_q;
  assign pop       = (state_q == ST_IDLE) && !empty;

  uart_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk,
    .reset_n,
    .push    (wr_en),
    .pop,
    .data_in,
    .data_out(head),
    .full,
    .empty
  );

  // Next-state: frame sequencing, tick count, shift and parity.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q != ST_IDLE && clk_enb)
      tick_d = tick_q + TICK_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        idx_d  = '0;
        stop_d = 1'b0;
        if (pop) begin
          shift_d = head;
          par_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (last_tick) begin
          tick_d  = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          tick_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          par_d   = par_q ^ shift_q[0];
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY
                                       : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (last_tick) begin
          tick_d  = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (last_tick) begin
          tick_d = '0;
          if (stop_last) state_d = ST_IDLE;
          else           stop_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the upcoming state, registered to avoid glitches.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d ^ (PARITY_ODD != 0);
      default:   tx_d = 1'b1;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Sticky drop flag; a drop wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n)          ovf_q <= 1'b0;
    else if (wr_en && full) ovf_q <= 1'b1;
    else if (ovf_clr)      ovf_q <= 1'b0;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for four uart_tx configurations.
// Monitors decode frames tick by tick and compare to queued bytes.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_enb;
  logic [3:0] wr_en;
  logic [3:0] ovf_clr;
  logic [7:0] din [4];
  logic [3:0] tx_w, busy_w, full_w, empty_w, ovf_w;
  bit         freeze = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         div = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         abort;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  uart_tx #(.DEPTH(4)) u0 (
    .clk, .reset_n, .clk_enb,
    .wr_en(wr_en[0]), .data_in(din[0]),
    .ovf_clr(ovf_clr[0]), .tx(tx_w[0]),
    .busy(busy_w[0]), .full(full_w[0]),
    .empty(empty_w[0]), .overflow(ovf_w[0]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk, .reset_n, .clk_enb,
    .wr_en(wr_en[1]), .data_in(din[1]),
    .ovf_clr(ovf_clr[1]), .tx(tx_w[1]),
    .busy(busy_w[1]), .full(full_w[1]),
    .empty(empty_w[1]), .overflow(ovf_w[1]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk, .reset_n, .clk_enb,
    .wr_en(wr_en[2]), .data_in(din[2]),
    .ovf_clr(ovf_clr[2]), .tx(tx_w[2]),
    .busy(busy_w[2]), .full(full_w[2]),
    .empty(empty_w[2]), .overflow(ovf_w[2]));

  uart_tx #(.STOP_BITS(2)) u3 (
    .clk, .reset_n, .clk_enb,
    .wr_en(wr_en[3]), .data_in(din[3]),
    .ovf_clr(ovf_clr[3]), .tx(tx_w[3]),
    .busy(busy_w[3]), .full(full_w[3]),
    .empty(empty_w[3]), .overflow(ovf_w[3]));

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(logic [7:0] d, logic p, bit a);
    exp_t e;
    e.data  = d;
    e.par   = p;
    e.abort = a;
    return e;
  endfunction

  function automatic int pen(int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int nstop(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic void push_exp(int i, exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic int qsize(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  // Decode one frame per start bit, checking every clk of each bit.
  task automatic monitor(int i);
    exp_t e;
    int nb, t, b;
    logic [15:0] bits;
    logic [7:0] d;
    bit bad, ab;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1 || tx_w[i] !== 1'b0) continue;
      chk($sformatf("frame_expected%0d", i), qsize(i) != 0, 1);
      e = (qsize(i) != 0) ? pop_exp(i) : mk(8'h00, 1'b0, 1'b0);
      nb = (1 + 8 + pen(i) + nstop(i)) * 16;
      t = 0; b = -1; bad = 0; ab = 0; bits = '0;
      while (1) begin
        if (!reset_n) begin ab = 1; break; end
        if (t / 16 != b) begin
          b = t / 16;
          bits[b] = tx_w[i];
        end else if (tx_w[i] !== bits[b]) bad = 1;
        if (clk_enb) t++;
        if (t >= nb) break;
        @(negedge clk);
      end
      if (ab) begin
        chk($sformatf("abort_expected%0d", i), e.abort, 1);
        continue;
      end
      chk($sformatf("abort_missing%0d", i), e.abort, 0);
      for (int k = 0; k < 8; k++) d[k] = bits[1 + k];
      chk($sformatf("data%0d", i), d, e.data);
      if (pen(i) != 0)
        chk($sformatf("parity%0d", i), bits[9], e.par);
      for (int s = 0; s < nstop(i); s++)
        chk($sformatf("stop%0d_%0d", i, s),
            bits[9 + pen(i) + s], 1);
      chk($sformatf("bit_stable%0d", i), bad, 0);
      @(negedge clk);
      chk($sformatf("end_busy%0d", i), busy_w[i], 0);
      chk($sformatf("end_tx%0d", i), tx_w[i], 1);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_mon
    initial monitor(g);
  end

  // 16x tick: one clk wide every third clk, gated by freeze.
  initial begin
    clk_enb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div == 2) ? 0 : div + 1;
      clk_enb = (div == 0) && !freeze;
    end
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(int i, logic [7:0] d);
    @(posedge clk); #1;
    wr_en[i] = 1'b1;
    din[i]   = d;
  endtask

  task automatic idle(int i);
    @(posedge clk); #1;
    wr_en[i]   = 1'b0;
    ovf_clr[i] = 1'b0;
  endtask

  task automatic wait_drain(int i, int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (qsize(i) == 0 && !busy_w[i] && empty_w[i]) break;
    end
    chk($sformatf("drain_in_time%0d", i), n < budget, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy(int i);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy_w[i]) break;
    end
    chk($sformatf("busy_in_time%0d", i), n < 200, 1);
  endtask

  task automatic count_ticks(int n);
    int c = 0;
    while (1) begin
      if (clk_enb) c++;
      if (c >= n) break;
      @(negedge clk);
    end
  endtask

  initial begin
    logic v;
    bit stable, seen;
    reset_n = 1'b0;
    wr_en   = '0;
    ovf_clr = '0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx_w, 4'hF);
    chk("rst_busy", busy_w, 4'h0);
    chk("rst_full", full_w, 4'h0);
    chk("rst_empty", empty_w, 4'hF);
    chk("rst_ovf", ovf_w, 4'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    push_exp(0, mk(8'h55, 1'b0, 1'b0));
    drive(0, 8'h55);
    idle(0);
    @(negedge clk);
    chk("n1_empty", empty_w[0], 0);
    chk("n1_busy", busy_w[0], 0);
    chk("n1_tx", tx_w[0], 1);
    @(negedge clk);
    chk("n2_busy", busy_w[0], 1);
    chk("n2_tx", tx_w[0], 0);
    chk("n2_empty", empty_w[0], 1);
    wait_drain(0, 2000);

    push_exp(1, mk(8'h07, 1'b1, 1'b0));
    push_exp(1, mk(8'h55, 1'b0, 1'b0));
    push_exp(2, mk(8'h07, 1'b0, 1'b0));
    push_exp(2, mk(8'h55, 1'b1, 1'b0));
    drive(1, 8'h07);
    drive(1, 8'h55);
    idle(1);
    drive(2, 8'h07);
    drive(2, 8'h55);
    idle(2);
    wait_drain(1, 3000);
    wait_drain(2, 3000);

    push_exp(3, mk(8'hA3, 1'b0, 1'b0));
    push_exp(3, mk(8'h3C, 1'b0, 1'b0));
    drive(3, 8'hA3);
    drive(3, 8'h3C);
    idle(3);
    wait_drain(3, 3000);

    push_exp(0, mk(8'h11, 1'b0, 1'b0));
    push_exp(0, mk(8'h22, 1'b0, 1'b0));
    push_exp(0, mk(8'h33, 1'b0, 1'b0));
    push_exp(0, mk(8'h44, 1'b0, 1'b0));
    push_exp(0, mk(8'h5A, 1'b0, 1'b0));
    drive(0, 8'h11);
    drive(0, 8'h22);
    drive(0, 8'h33);
    drive(0, 8'h44);
    drive(0, 8'h5A);
    drive(0, 8'h66);
    idle(0);
    @(negedge clk);
    chk("ovf_full", full_w[0], 1);
    chk("ovf_set", ovf_w[0], 1);
    @(posedge clk); #1;
    wr_en[0] = 1'b1; din[0] = 8'h77; ovf_clr[0] = 1'b1;
    idle(0);
    @(negedge clk);
    chk("ovf_drop_wins", ovf_w[0], 1);
    @(posedge clk); #1 ovf_clr[0] = 1'b1;
    idle(0);
    @(negedge clk);
    chk("ovf_cleared", ovf_w[0], 0);
    chk("ovf_still_full", full_w[0], 1);
    wait_drain(0, 4000);

    push_exp(0, mk(8'hFF, 1'b0, 1'b1));
    drive(0, 8'hFF);
    drive(0, 8'h12);
    idle(0);
    wait_busy(0);
    count_ticks(72);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tx", tx_w[0], 1);
    chk("mid_rst_busy", busy_w[0], 0);
    chk("mid_rst_empty", empty_w[0], 1);
    @(posedge clk); #1 reset_n = 1'b1;
    seen = 0;
    repeat (600) begin
      @(negedge clk);
      if (busy_w[0] || !tx_w[0]) seen = 1;
    end
    chk("no_residual", seen, 0);
    chk("abort_popped", qsize(0), 0);

    push_exp(0, mk(8'h9A, 1'b0, 1'b0));
    drive(0, 8'h9A);
    idle(0);
    wait_busy(0);
    count_ticks(53);
    freeze = 1'b1;
    @(negedge clk);
    v = tx_w[0];
    chk("freeze_bit2", v, 0);
    stable = 1;
    repeat (100) begin
      @(negedge clk);
      if (tx_w[0] !== v || clk_enb) stable = 0;
    end
    chk("freeze_stable", stable, 1);
    freeze = 1'b0;
    wait_drain(0, 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: the transmit-side counterpart of the 16x-oversampled receiver. It accepts bytes through a write strobe into a small FIFO and serialises each byte onto `tx` as 8N1/8E1/8O1/8N2 frames. Bit timing comes from the shared 16x `clk_enb` sampling tick, so one generator drives both directions. The block sits between the host-side register interface and the serial pin.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `PARITY_EN`, 0: 1 inserts a parity bit after data bit 7.
- `PARITY_ODD`, 0: parity sense when `PARITY_EN`=1 (0 even, 1 odd).
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `clk_enb` in 1: 16x bit-rate tick, one `clk` wide.
- `wr_en` in 1: push `data_in` into the FIFO.
- `data_in` in 8: byte to send.
- `ovf_clr` in 1: clears `overflow`.
- `tx` out 1: serial line, idle high.
- `busy` out 1: a frame is in progress (state ≠ Idle).
- `full` out 1: FIFO count == `DEPTH`.
- `empty` out 1: FIFO count == 0.
- `overflow` out 1: sticky; a push was dropped.

## Operation
- FSM states: Idle, Start, Data, Parity, Stop.
- Idle: `tx`=1, tick counter and bit index held at 0. If the registered FIFO count ≠ 0, pop the head into the shift register and go to Start. `clk_enb` is not required for this transition.
- Start: `tx`=0. Count `clk_enb` ticks 0..15. On the tick where the count is 15, clear the count and go to Data with index 0.
- Data: `tx`=shift[0], LSB first. On tick 15, shift right and fold the bit into the parity accumulator. At index 7, go to Parity if `PARITY_EN` else Stop; otherwise increment the index.
- Parity: `tx`=XOR of the data bits XOR `PARITY_ODD`. Hold for 16 ticks, then go to Stop.
- Stop: `tx`=1 for 16×`STOP_BITS` ticks, then go to Idle.
- `tx` is driven from a register, so it never glitches.
- FIFO push: `wr_en` with `full`=0 writes `data_in` at the write pointer. `wr_en` with `full`=1 drops the byte and sets `overflow`.
- `ovf_clr` clears `overflow`. If `ovf_clr` and a dropped push occur in the same cycle, `overflow` ends set.
- Pointers are log2(`DEPTH`) bits wide and wrap naturally. The count is log2(`DEPTH`)+1 bits wide.
- Push and pop in the same cycle: both take effect and the count is unchanged. `full` and `empty` are evaluated from the registered count, so a push into a full FIFO is dropped even if a pop happens in the same cycle.
- A byte pushed into an empty FIFO is popped no earlier than the following cycle.
- Default state: Idle with all counters cleared.

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `overflow`=0. The FIFO is flushed and the FSM is in Idle.
- Reset mid-frame aborts the frame. `tx` is 1 on the edge after `reset_n` samples low.
- Push to line: a push in cycle N into an empty FIFO with the FSM idle:
  - `empty` falls at N+1.
  - The pop happens at N+1.
  - `tx`=0 and `busy`=1 from N+2.
- Each bit lasts exactly 16 `clk_enb` ticks. The start bit's first tick is the first `clk_enb` seen while in Start.
- Frame length is (1+8+`PARITY_EN`+`STOP_BITS`)×16 ticks.
- Back-to-back frames: at least one `clk` of Idle (`tx`=1) separates the end of Stop and the next Start. There is no added tick-level gap.
- `clk_enb` held low freezes the current bit indefinitely.

## Structure
- Shared package `uart_pkg`:
  - `OVERSAMPLE`=16 and the half-count derived from it, also used by the receiver.
  - Typedef `uart_tx_state_t` (2-bit enum plus Parity, so 3 bits).
- Sub-module `uart_tx_fifo`, parameterised on `DEPTH`:
  - Ports: push/pop, `data_in`, `data_out`, `full`, `empty`.
  - Instantiated once.
- The FSM, shift register, parity accumulator and tick counter live in `uart_tx`.

## Test plan
- Defaults, push 0x55: `tx` is 0, then 1,0,1,0,1,0,1,0, then 1. Each bit lasts 16 ticks. `busy` falls after 160 ticks plus 1 clk.
- `PARITY_EN`=1, `PARITY_ODD`=0, push 0x07: data bits 1,1,1,0,0,0,0,0, then parity bit 1. With `PARITY_ODD`=1 the parity bit is 0.
- `STOP_BITS`=2, push 0xA3 then 0x3C in consecutive cycles: two frames. Each stop phase lasts 32 ticks, with one idle clk between the frames.
- `DEPTH`=4 with the FSM busy, push 6 bytes in 6 cycles:
  - The first pushed byte is popped into the frame and 4 more fill the FIFO; `full` rises.
  - The 6th byte is dropped and `overflow`=1.
  - `ovf_clr` clears it.
  - Exactly 5 frames go out, in order.
- Assert `reset_n`=0 during data bit 3 of 0xFF: `tx`=1, `busy`=0 and `empty`=1 on the next edge. After release, no residual frame is sent.
- Hold `clk_enb`=0 for 100 clk mid-Data: `tx` is stable throughout, and the bit resumes with the remaining tick count preserved.
